// File: rtl/hue_ramp.sv
// hue_ramp: walks an RGB colour wheel through six phases, ramping one channel
// at a time by INC every TICK_DIV clocks. A ramp step is only taken on a
// period_done pulse from the downstream PWM, so new duty values land on PWM
// period boundaries.
//
// Handshake: period_done is a one-cycle strobe from the PWM. A pending tick
// is consumed by the first period_done that sees it. duty_valid is a one-cycle
// strobe in the cycle duty_r/g/b first show the new values. There is no
// back-pressure: the PWM must latch the duty in that cycle or at its next
// period end.
//
// Optional feature: define HUE_RAMP_HOLD_EN to add a 'hold' input. While hold
// is high the ramp freezes completely.
module hue_ramp #(
    parameter int PWM_INTERVAL = 1800,
    parameter int INC          = 10,
    parameter int TICK_DIV     = 60000,
    localparam int W           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         period_done,
`ifdef HUE_RAMP_HOLD_EN
    input  logic         hold,
`endif
    output logic [W-1:0] duty_r,
    output logic [W-1:0] duty_g,
    output logic [W-1:0] duty_b,
    output logic         duty_valid,
    output logic [2:0]   phase
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick_term;
    logic          pending;
    logic [W:0]    level;      // one extra bit so level + INC cannot overflow
    logic [W:0]    level_sum;
    logic          step;
    logic          step_q;
    logic          frozen;
    logic [W-1:0]  nxt_r;
    logic [W-1:0]  nxt_g;
    logic [W-1:0]  nxt_b;

`ifdef HUE_RAMP_HOLD_EN
    assign frozen = hold;
`else
    assign frozen = 1'b0;
`endif

    assign tick_term = (tick_cnt == TW'(TICK_DIV - 1));
    assign level_sum = level + (W+1)'(INC);
    // A tick arriving in the same cycle as period_done is used directly.
    assign step      = (pending | tick_term) & period_done & ~frozen;

    // Tick divider, pending tick flag and colour-wheel position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            pending  <= 1'b0;
            phase    <= 3'd0;
            level    <= '0;
        end else if (!frozen) begin
            tick_cnt <= tick_term ? '0 : tick_cnt + TW'(1);
            // Extra ticks while one is already pending are simply dropped.
            if (step)
                pending <= 1'b0;
            else if (tick_term)
                pending <= 1'b1;
            if (step) begin
                if (level_sum >= (W+1)'(PWM_INTERVAL)) begin
                    phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
                    level <= '0;
                end else begin
                    level <= level_sum;
                end
            end
        end
    end

    // Colour-wheel mapping from (phase, level) to the three channel duties.
    always_comb begin
        nxt_r = W'(PWM_INTERVAL);
        nxt_g = '0;
        nxt_b = '0;
        case (phase)
            3'd1: begin
                nxt_r = W'(PWM_INTERVAL) - level[W-1:0];
                nxt_g = W'(PWM_INTERVAL);
            end
            3'd2: begin
                nxt_r = '0;
                nxt_g = W'(PWM_INTERVAL);
                nxt_b = level[W-1:0];
            end
            3'd3: begin
                nxt_r = '0;
                nxt_g = W'(PWM_INTERVAL) - level[W-1:0];
                nxt_b = W'(PWM_INTERVAL);
            end
            3'd4: begin
                nxt_r = level[W-1:0];
                nxt_b = W'(PWM_INTERVAL);
            end
            3'd5: begin
                nxt_b = W'(PWM_INTERVAL) - level[W-1:0];
            end
            default: begin
                nxt_g = level[W-1:0];
            end
        endcase
    end

    // Registered duties, loaded only the cycle after a step so they never
    // move between period boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q     <= 1'b0;
            duty_valid <= 1'b0;
            duty_r     <= W'(PWM_INTERVAL);
            duty_g     <= '0;
            duty_b     <= '0;
        end else begin
            // A step caught by hold is delivered once hold drops.
            if (!frozen)
                step_q <= step;
            duty_valid <= step_q & ~frozen;
            if (step_q && !frozen) begin
                duty_r <= nxt_r;
                duty_g <= nxt_g;
                duty_b <= nxt_b;
            end
        end
    end

endmodule

// File: tb/tb_hue_ramp.sv
// tb_hue_ramp: directed checks of hue_ramp with PWM_INTERVAL=1800, INC=100,
// TICK_DIV=4. Define HUE_RAMP_HOLD_EN for both files to exercise hold.
module tb_hue_ramp;

  localparam int PI  = 1800;
  localparam int INC = 100;
  localparam int TD  = 4;
  localparam int W   = $clog2(PI + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         period_done = 1'b0;
`ifdef HUE_RAMP_HOLD_EN
  logic         hold = 1'b0;
`endif
  logic [W-1:0] duty_r;
  logic [W-1:0] duty_g;
  logic [W-1:0] duty_b;
  logic         duty_valid;
  logic [2:0]   phase;

  int pass_cnt = 0;
  int total_cnt = 0;

  hue_ramp #(.PWM_INTERVAL(PI), .INC(INC), .TICK_DIV(TD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .period_done(period_done),
`ifdef HUE_RAMP_HOLD_EN
    .hold(hold),
`endif
    .duty_r(duty_r),
    .duty_g(duty_g),
    .duty_b(duty_b),
    .duty_valid(duty_valid),
    .phase(phase)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // advance n rising edges, then settle 1ns past the edge
  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_clk(1);
      if (duty_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // reference colour wheel
  function automatic logic [3*W-1:0] hue(input int ph, input int lvl);
    int r, g, b;
    r = 0; g = 0; b = 0;
    case (ph)
      0: begin r = PI;       g = lvl;      b = 0;        end
      1: begin r = PI - lvl; g = PI;       b = 0;        end
      2: begin r = 0;        g = PI;       b = lvl;      end
      3: begin r = 0;        g = PI - lvl; b = PI;       end
      4: begin r = lvl;      g = 0;        b = PI;       end
      default: begin r = PI; g = 0;        b = PI - lvl; end
    endcase
    return {W'(r), W'(g), W'(b)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    period_done = 1'b0;
    step_clk(3);
    total_cnt++;
    if ({duty_r, duty_g, duty_b} !== {W'(1800), W'(0), W'(0)})
      $display("FAIL reset_duty: got %0d/%0d/%0d expected 1800/0/0", duty_r, duty_g, duty_b);
    else pass_cnt++;
    total_cnt++;
    if ({duty_valid, phase} !== 4'b0)
      $display("FAIL reset_ctrl: got valid=%0b phase=%0d expected valid=0 phase=0", duty_valid, phase);
    else pass_cnt++;
  endtask

  task automatic test_first_step();
    logic [4:0] vbits;
    rst_n = 1'b0;
    period_done = 1'b1;
    step_clk(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_clk(1);
      vbits[i] = duty_valid;
    end
    total_cnt++;
    if (vbits !== 5'b10000)
      $display("FAIL first_valid_timing: got valid pattern %b expected 10000", vbits);
    else pass_cnt++;
    total_cnt++;
    if ({duty_r, duty_g, duty_b} !== {W'(1800), W'(100), W'(0)})
      $display("FAIL first_duty: got %0d/%0d/%0d expected 1800/100/0", duty_r, duty_g, duty_b);
    else pass_cnt++;
    for (int k = 2; k <= 3; k++) begin
      step_clk(4);
      total_cnt++;
      if ({duty_valid, duty_g} !== {1'b1, W'(100 * k)})
        $display("FAIL periodic_step%0d: got valid=%0b G=%0d expected valid=1 G=%0d", k, duty_valid, duty_g, 100 * k);
      else pass_cnt++;
    end
  endtask

  task automatic test_boundary();
    bit got;
    int model_err, cont_err, dr, dg, db;
    logic [3*W-1:0] prev;
    model_err = 0;
    cont_err = 0;
    rst_n = 1'b0;
    period_done = 1'b1;
    step_clk(2);
    rst_n = 1'b1;
    prev = {duty_r, duty_g, duty_b};
    for (int k = 1; k <= 108; k++) begin
      wait_valid(8, got);
      if (!got) begin
        total_cnt++;
        $display("FAIL boundary_timeout: no duty_valid for step %0d", k);
        break;
      end
      if ({duty_r, duty_g, duty_b} !== hue((k / 18) % 6, (k % 18) * 100) || phase !== 3'((k / 18) % 6))
        model_err++;
      dr = int'(duty_r) - int'(prev[3*W-1:2*W]);
      dg = int'(duty_g) - int'(prev[2*W-1:W]);
      db = int'(duty_b) - int'(prev[W-1:0]);
      if (dr > INC || dr < -INC || dg > INC || dg < -INC || db > INC || db < -INC)
        cont_err++;
      prev = {duty_r, duty_g, duty_b};
      if (k == 18) begin
        total_cnt++;
        if ({phase, duty_r, duty_g, duty_b} !== {3'd1, W'(1800), W'(1800), W'(0)})
          $display("FAIL step18: got phase=%0d %0d/%0d/%0d expected 1 1800/1800/0", phase, duty_r, duty_g, duty_b);
        else pass_cnt++;
      end
      if (k == 19) begin
        total_cnt++;
        if ({duty_r, duty_g, duty_b} !== {W'(1700), W'(1800), W'(0)})
          $display("FAIL step19: got %0d/%0d/%0d expected 1700/1800/0", duty_r, duty_g, duty_b);
        else pass_cnt++;
      end
      if (k == 108) begin
        total_cnt++;
        if ({phase, duty_r, duty_g, duty_b} !== {3'd0, W'(1800), W'(0), W'(0)})
          $display("FAIL step108: got phase=%0d %0d/%0d/%0d expected 0 1800/0/0", phase, duty_r, duty_g, duty_b);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (model_err !== 0)
      $display("FAIL ramp_model: got %0d mismatching steps expected 0", model_err);
    else pass_cnt++;
    total_cnt++;
    if (cont_err !== 0)
      $display("FAIL continuity: got %0d jumps larger than INC expected 0", cont_err);
    else pass_cnt++;
  endtask

  task automatic test_drop();
    int quiet_err;
    logic [3*W-1:0] snap;
    rst_n = 1'b0;
    period_done = 1'b0;
    step_clk(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      quiet_err = 0;
      snap = {duty_r, duty_g, duty_b};
      repeat (19) begin
        step_clk(1);
        if (duty_valid || {duty_r, duty_g, duty_b} !== snap) quiet_err++;
      end
      total_cnt++;
      if (quiet_err !== 0)
        $display("FAIL drop_quiet%0d: got %0d cycles with change expected 0", i, quiet_err);
      else pass_cnt++;
      period_done = 1'b1;
      step_clk(1);
      period_done = 1'b0;
      step_clk(1);
      total_cnt++;
      if ({duty_valid, duty_r, duty_g} !== {1'b1, W'(1800), W'(100 * i)})
        $display("FAIL drop_step%0d: got valid=%0b R=%0d G=%0d expected valid=1 R=1800 G=%0d", i, duty_valid, duty_r, duty_g, 100 * i);
      else pass_cnt++;
    end
  endtask

  task automatic test_same_cycle();
    logic [2:0] vbits;
    rst_n = 1'b0;
    period_done = 1'b0;
    step_clk(2);
    rst_n = 1'b1;
    step_clk(3);
    period_done = 1'b1;
    step_clk(1);
    period_done = 1'b0;
    step_clk(1);
    total_cnt++;
    if ({duty_valid, duty_g} !== {1'b1, W'(100)})
      $display("FAIL same_cycle_step: got valid=%0b G=%0d expected valid=1 G=100", duty_valid, duty_g);
    else pass_cnt++;
    period_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clk(1);
      vbits[i] = duty_valid;
    end
    step_clk(1);
    period_done = 1'b0;
    total_cnt++;
    if ({vbits, duty_valid, duty_g} !== {3'b000, 1'b1, W'(200)})
      $display("FAIL same_cycle_pending: got early=%b valid=%0b G=%0d expected early=000 valid=1 G=200", vbits, duty_valid, duty_g);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit got;
    rst_n = 1'b0;
    period_done = 1'b1;
    step_clk(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 58; k++) begin
      wait_valid(8, got);
      if (!got) break;
    end
    total_cnt++;
    if ({phase, duty_r, duty_g, duty_b} !== {3'd3, W'(0), W'(1400), W'(1800)})
      $display("FAIL async_pre: got phase=%0d %0d/%0d/%0d expected 3 0/1400/1800", phase, duty_r, duty_g, duty_b);
    else pass_cnt++;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({duty_valid, phase, duty_r, duty_g, duty_b} !== {1'b0, 3'd0, W'(1800), W'(0), W'(0)})
      $display("FAIL async_reset: got valid=%0b phase=%0d %0d/%0d/%0d expected 0 0 1800/0/0", duty_valid, phase, duty_r, duty_g, duty_b);
    else pass_cnt++;
    period_done = 1'b0;
    step_clk(2);
  endtask

`ifdef HUE_RAMP_HOLD_EN
  task automatic test_hold();
    bit got;
    int vcount;
    logic [3*W+2:0] snap;
    rst_n = 1'b0;
    period_done = 1'b1;
    step_clk(2);
    rst_n = 1'b1;
    wait_valid(8, got);
    wait_valid(8, got);
    hold = 1'b1;
    snap = {phase, duty_r, duty_g, duty_b};
    vcount = 0;
    repeat (50) begin
      step_clk(1);
      if (duty_valid) vcount++;
    end
    total_cnt++;
    if (vcount !== 0 || {phase, duty_r, duty_g, duty_b} !== snap)
      $display("FAIL hold_frozen: got %0d pulses G=%0d expected 0 pulses G=200", vcount, duty_g);
    else pass_cnt++;
    hold = 1'b0;
    wait_valid(8, got);
    total_cnt++;
    if ({got, duty_g} !== {1'b1, W'(300)})
      $display("FAIL hold_resume: got valid=%0b G=%0d expected valid=1 G=300", got, duty_g);
    else pass_cnt++;
    period_done = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_step();
    test_boundary();
    test_drop();
    test_same_cycle();
    test_async_reset();
`ifdef HUE_RAMP_HOLD_EN
    test_hold();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hue_ramp.md
HUE_RAMP -- requirements
Module: hue_ramp

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1800, full-scale duty value (one PWM period in clocks).
REQ-002 SHALL have parameter INC, default 10, duty increment per ramp step; legal range 1..PWM_INTERVAL.
REQ-003 SHALL have parameter TICK_DIV, default 60000, clocks between ramp-step requests; legal range >=1.
REQ-004 SHALL define localparam W = $clog2(PWM_INTERVAL+1), the duty width.
REQ-005 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port period_done  input  1  one-cycle pulse from downstream PWM at the end of each PWM period.
REQ-008 SHALL have port duty_r  output  W  red duty, 0..PWM_INTERVAL.
REQ-009 SHALL have port duty_g  output  W  green duty, 0..PWM_INTERVAL.
REQ-010 SHALL have port duty_b  output  W  blue duty, 0..PWM_INTERVAL.
REQ-011 SHALL have port duty_valid  output  1  one-cycle pulse in the cycle duty_r/g/b take new values.
REQ-012 SHALL have port phase  output  3  current colour-wheel phase, 0..5.

Function
REQ-013 SHALL run a tick counter 0..TICK_DIV-1; on its terminal count it wraps to 0 and sets a pending flag.
REQ-014 SHALL perform a ramp step only in a cycle where pending=1 (registered) or the tick terminal occurs, and period_done=1; the step clears pending.
REQ-015 Ticks arriving while pending is already set SHALL be dropped, never queued (at most one step per period_done).
REQ-016 On a step, if level+INC >= PWM_INTERVAL, phase SHALL advance (5 wraps to 0) and level SHALL become 0; otherwise level SHALL become level+INC.
REQ-017 The level register SHALL be W+1 bits wide internally so level+INC never overflows.
REQ-018 Duty outputs SHALL be registered; they SHALL be updated one clock after the state update, as a pure function of (phase, level).
REQ-019 The mapping SHALL be: phase0 R=MAX G=level B=0; phase1 R=MAX-level G=MAX B=0; phase2 R=0 G=MAX B=level; phase3 R=0 G=MAX-level B=MAX; phase4 R=level G=0 B=MAX; phase5 R=MAX G=0 B=MAX-level. MAX=PWM_INTERVAL.
REQ-020 duty_valid SHALL pulse high for exactly the one cycle in which the new duty values first appear, i.e. one cycle after the step.
REQ-021 Outputs SHALL change only on step cycles, so the downstream PWM latches new duty only at period boundaries (glitch-free).
REQ-022 Phase-boundary continuity: the last duty of a phase and the first duty of the next phase SHALL differ by at most INC per channel.

Reset
REQ-023 While rst_n=0 SHALL hold: tick counter 0, pending 0, phase 0, level 0, duty_r=PWM_INTERVAL, duty_g=0, duty_b=0, duty_valid 0.
REQ-024 Reset asserted mid-ramp SHALL take effect immediately, without waiting for a clock; the first tick after release SHALL occur TICK_DIV clocks after the first clk edge with rst_n=1.

Configuration
REQ-025 Macro HUE_RAMP_HOLD_EN defined: SHALL add port hold  input  1; while hold=1, the tick counter, pending, phase and level are frozen, no steps occur, and duty_valid stays 0.
REQ-026 HUE_RAMP_HOLD_EN undefined: port hold SHALL NOT exist; behaviour is identical to hold tied to 0.

Verification (PWM_INTERVAL=1800, INC=100, TICK_DIV=4 unless stated)
REQ-027 Reset release, period_done tied high -> the first duty_valid pulse occurs 5 clocks after release with R=1800 G=100 B=0, then every 4 clocks G steps by 100.
REQ-028 Ramp across a boundary -> after 18 steps, phase=1 R=1800 G=1800 B=0; the next step gives R=1700 G=1800; after 108 steps phase=0 R=1800 G=0 B=0.
REQ-029 period_done pulsed every 20 clocks -> exactly one step per period_done, 4 ticks dropped between steps, no duty change between period_done pulses.
REQ-030 Tick terminal and period_done in the same cycle with pending=0 -> the step occurs in that cycle and pending stays 0.
REQ-031 rst_n asserted low asynchronously mid phase 3 -> outputs go to 1800/0/0 with duty_valid=0 before the next clk edge.
REQ-032 With HUE_RAMP_HOLD_EN, hold=1 for 50 clocks -> no duty_valid pulse and state unchanged; after hold=0, stepping resumes from the frozen level.
